// File: rtl/inta_sequencer_if.sv
// CPU-side acknowledge bus of the interrupt-acknowledge sequencer:
// INTA strobe in; INT request, cascade gate and vector byte out.
interface inta_sequencer_if;
  logic       INTA_N;
  logic       INT;
  logic       INTA_2;
  logic [7:0] Data_out;
  logic       Data_en;

  modport master (
    output INTA_N,
    input  INT, INTA_2, Data_out, Data_en
  );

  modport slave (
    input  INTA_N,
    output INT, INTA_2, Data_out, Data_en
  );
endinterface

// File: rtl/inta_sequencer.sv
// 8086-mode interrupt-acknowledge sequencer for an 8259A-style PIC:
// raises INT, follows the two INTA pulses, sets/clears ISR and places the vector.
module inta_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  inta_sequencer_if.slave  bus,
  input  logic             Init_clr,
  input  logic             Req_valid,
  input  logic [2:0]       Req_index,
  input  logic             SNGL,
  input  logic             Master_Slave,
  input  logic [2:0]       ID,
  input  logic [2:0]       Own_ID,
  input  logic [7:0]       Slave_map,
  input  logic             AEOI,
  input  logic [4:0]       Vector_base,
  output logic             ISR_set,
  output logic             ISR_clear,
  output logic [2:0]       ISR_index,
  output logic             Freeze
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK1  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_ACK2  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   inta_prev_q, inta_prev_d;
  logic                   int_q, int_d;
  logic                   inta_2_q, inta_2_d;
  logic                   freeze_q, freeze_d;
  logic                   data_en_q, data_en_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   isr_set_q, isr_set_d;
  logic                   isr_clear_q, isr_clear_d;
  logic [2:0]             isr_index_q, isr_index_d;
  logic [2:0]             cur_index_q, cur_index_d;
  logic                   spurious_q, spurious_d;
  logic                   inta_sync_s, fall_s, rise_s;

  // A lone PIC always answers; a master defers to a cascaded slave; a slave answers only when addressed.
  function automatic logic drive_decision(
    input logic       sngl,
    input logic       master,
    input logic [7:0] slave_map,
    input logic [2:0] cur_index,
    input logic [2:0] id,
    input logic [2:0] own_id
  );
    logic drive;
    if (sngl) begin
      drive = 1'b1;
    end else if (master) begin
      drive = ~slave_map[cur_index];
    end else begin
      drive = (id == own_id);
    end
    return drive;
  endfunction

  assign inta_sync_s = sync_q[SYNC_STAGES-1];
  assign fall_s      = inta_prev_q & ~inta_sync_s;
  assign rise_s      = ~inta_prev_q & inta_sync_s;

  // Next-state and registered-output computation.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bus.INTA_N};
    inta_prev_d = inta_sync_s;
    state_d     = state_q;
    int_d       = int_q;
    inta_2_d    = inta_2_q;
    freeze_d    = freeze_q;
    data_en_d   = data_en_q;
    data_out_d  = data_out_q;
    isr_set_d   = 1'b0;
    isr_clear_d = 1'b0;
    isr_index_d = isr_index_q;
    cur_index_d = cur_index_q;
    spurious_d  = spurious_q;

    if (Init_clr) begin
      state_d    = ST_IDLE;
      int_d      = 1'b0;
      inta_2_d   = 1'b0;
      freeze_d   = 1'b0;
      data_en_d  = 1'b0;
      data_out_d = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Req_valid) begin
            state_d = ST_REQ;
            int_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          // INT is held even if the request vanishes: the CPU is already committed.
          if (fall_s) begin
            state_d     = ST_ACK1;
            int_d       = 1'b0;
            freeze_d    = 1'b1;
            spurious_d  = ~Req_valid;
            cur_index_d = Req_valid ? Req_index : 3'd7;
            isr_index_d = Req_valid ? Req_index : 3'd7;
            isr_set_d   = Req_valid;
          end else begin
            int_d = 1'b1;
          end
        end
        ST_ACK1: begin
          if (rise_s) begin
            state_d  = ST_WAIT2;
            inta_2_d = 1'b1;
          end else begin
            state_d = ST_ACK1;
          end
        end
        ST_WAIT2: begin
          if (fall_s) begin
            state_d = ST_ACK2;
            data_en_d = drive_decision(SNGL, Master_Slave, Slave_map,
                                       cur_index_q, ID, Own_ID);
            data_out_d = data_en_d ? {Vector_base, cur_index_q} : 8'h00;
          end else begin
            state_d = ST_WAIT2;
          end
        end
        ST_ACK2: begin
          if (rise_s) begin
            state_d     = ST_IDLE;
            data_en_d   = 1'b0;
            data_out_d  = 8'h00;
            inta_2_d    = 1'b0;
            freeze_d    = 1'b0;
            isr_clear_d = AEOI & ~spurious_q;
          end else begin
            state_d = ST_ACK2;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          int_d      = 1'b0;
          inta_2_d   = 1'b0;
          freeze_d   = 1'b0;
          data_en_d  = 1'b0;
          data_out_d = 8'h00;
        end
      endcase
    end
  end

  // State, synchroniser and output registers; synchroniser idles at 1 (INTA inactive).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sync_q      <= {SYNC_STAGES{1'b1}};
      inta_prev_q <= 1'b1;
      int_q       <= 1'b0;
      inta_2_q    <= 1'b0;
      freeze_q    <= 1'b0;
      data_en_q   <= 1'b0;
      data_out_q  <= 8'h00;
      isr_set_q   <= 1'b0;
      isr_clear_q <= 1'b0;
      isr_index_q <= 3'd0;
      cur_index_q <= 3'd0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      inta_prev_q <= inta_prev_d;
      int_q       <= int_d;
      inta_2_q    <= inta_2_d;
      freeze_q    <= freeze_d;
      data_en_q   <= data_en_d;
      data_out_q  <= data_out_d;
      isr_set_q   <= isr_set_d;
      isr_clear_q <= isr_clear_d;
      isr_index_q <= isr_index_d;
      cur_index_q <= cur_index_d;
      spurious_q  <= spurious_d;
    end
  end

  assign bus.INT      = int_q;
  assign bus.INTA_2   = inta_2_q;
  assign bus.Data_en  = data_en_q;
  assign bus.Data_out = data_out_q;
  assign ISR_set      = isr_set_q;
  assign ISR_clear    = isr_clear_q;
  assign ISR_index    = isr_index_q;
  assign Freeze       = freeze_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed scoreboard bench for inta_sequencer: expectations are queued when a
// sequence is launched and consumed in order as DUT outputs are sampled.
module tb_inta_sequencer;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } sb_item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, init_clr, req_valid, sngl, master_slave, aeoi;
  logic [2:0] req_index, id, own_id, isr_index;
  logic [7:0] slave_map;
  logic [4:0] vector_base;
  logic       isr_set, isr_clear, freeze;

  sb_item_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  inta_sequencer_if bus_if();

  inta_sequencer #(.SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if.slave),
    .Init_clr     (init_clr),
    .Req_valid    (req_valid),
    .Req_index    (req_index),
    .SNGL         (sngl),
    .Master_Slave (master_slave),
    .ID           (id),
    .Own_ID       (own_id),
    .Slave_map    (slave_map),
    .AEOI         (aeoi),
    .Vector_base  (vector_base),
    .ISR_set      (isr_set),
    .ISR_clear    (isr_clear),
    .ISR_index    (isr_index),
    .Freeze       (freeze)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    sb_item_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs);
    sb_item_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty observed=%0h", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s/%s observed=%0h expected=%0h", tag, e.tag, obs, e.val);
      end
    end
  endtask

  // One full acknowledge: request, first pulse, second pulse, completion.
  task automatic run_ack(input logic [2:0] idx, input logic spur,
                         input logic drv, input logic clr);
    logic [2:0] ei;
    logic [7:0] eo;
    ei = spur ? 3'd7 : idx;
    eo = drv ? {vector_base, ei} : 8'h00;
    push("int_req", 8'd1);
    if (spur) push("int_hold", 8'd1);
    push("int_ack", 8'd0);
    push("freeze_ack", 8'd1);
    push("isr_set", {7'd0, ~spur});
    push("isr_index", {5'd0, ei});
    push("isr_set_end", 8'd0);
    push("inta2", 8'd1);
    push("data_en", {7'd0, drv});
    push("data_out", eo);
    push("data_en_end", 8'd0);
    push("inta2_end", 8'd0);
    push("freeze_end", 8'd0);
    push("isr_clear", {7'd0, clr});
    push("isr_index_end", {5'd0, ei});
    push("isr_clear_end", 8'd0);

    req_valid = 1'b1;
    req_index = idx;
    tick();
    chk("int_req", {7'd0, bus_if.INT});
    if (spur) begin
      req_valid = 1'b0;
      tick();
      chk("int_hold", {7'd0, bus_if.INT});
    end
    bus_if.INTA_N = 1'b0;
    ticks(LAT);
    chk("int_ack", {7'd0, bus_if.INT});
    chk("freeze_ack", {7'd0, freeze});
    chk("isr_set", {7'd0, isr_set});
    chk("isr_index", {5'd0, isr_index});
    req_valid = 1'b0;
    tick();
    chk("isr_set_end", {7'd0, isr_set});
    bus_if.INTA_N = 1'b1;
    ticks(LAT);
    chk("inta2", {7'd0, bus_if.INTA_2});
    bus_if.INTA_N = 1'b0;
    ticks(LAT);
    chk("data_en", {7'd0, bus_if.Data_en});
    chk("data_out", bus_if.Data_out);
    bus_if.INTA_N = 1'b1;
    ticks(LAT);
    chk("data_en_end", {7'd0, bus_if.Data_en});
    chk("inta2_end", {7'd0, bus_if.INTA_2});
    chk("freeze_end", {7'd0, freeze});
    chk("isr_clear", {7'd0, isr_clear});
    chk("isr_index_end", {5'd0, isr_index});
    tick();
    chk("isr_clear_end", {7'd0, isr_clear});
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 8; i++) push(tag, 8'd0);
    chk({tag, "_int"}, {7'd0, bus_if.INT});
    chk({tag, "_inta2"}, {7'd0, bus_if.INTA_2});
    chk({tag, "_freeze"}, {7'd0, freeze});
    chk({tag, "_data_en"}, {7'd0, bus_if.Data_en});
    chk({tag, "_data_out"}, bus_if.Data_out);
    chk({tag, "_isr_set"}, {7'd0, isr_set});
    chk({tag, "_isr_clear"}, {7'd0, isr_clear});
    chk({tag, "_isr_index"}, {5'd0, isr_index});
  endtask

  initial begin
    reset_n       = 1'b0;
    init_clr      = 1'b0;
    req_valid     = 1'b0;
    req_index     = 3'd0;
    sngl          = 1'b1;
    master_slave  = 1'b1;
    id            = 3'd0;
    own_id        = 3'd0;
    slave_map     = 8'h00;
    aeoi          = 1'b0;
    vector_base   = 5'b01000;
    bus_if.INTA_N = 1'b1;
    ticks(2);
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Single PIC, AEOI off: vector 8'h43.
    run_ack(3'd3, 1'b0, 1'b1, 1'b0);
    // Spurious: request withdrawn before first fall, vector 8'h47.
    run_ack(3'd3, 1'b1, 1'b1, 1'b0);

    // Cascade master with slave on IR2.
    sngl         = 1'b0;
    master_slave = 1'b1;
    slave_map    = 8'h04;
    run_ack(3'd2, 1'b0, 1'b0, 1'b0);
    run_ack(3'd5, 1'b0, 1'b1, 1'b0);

    // Cascade slave with AEOI.
    master_slave = 1'b0;
    own_id       = 3'd2;
    aeoi         = 1'b1;
    id           = 3'd2;
    run_ack(3'd1, 1'b0, 1'b1, 1'b1);
    id           = 3'd4;
    run_ack(3'd1, 1'b0, 1'b0, 1'b1);

    // Init_clr coincident with the first fall wins.
    sngl = 1'b1;
    push("coinc_int_req", 8'd1);
    push("coinc_int", 8'd0);
    push("coinc_freeze", 8'd0);
    push("coinc_isr_set", 8'd0);
    push("coinc_inta2", 8'd0);
    req_valid = 1'b1;
    req_index = 3'd6;
    tick();
    chk("coinc_int_req", {7'd0, bus_if.INT});
    bus_if.INTA_N = 1'b0;
    ticks(LAT - 1);
    init_clr = 1'b1;
    tick();
    init_clr  = 1'b0;
    req_valid = 1'b0;
    chk("coinc_int", {7'd0, bus_if.INT});
    chk("coinc_freeze", {7'd0, freeze});
    chk("coinc_isr_set", {7'd0, isr_set});
    bus_if.INTA_N = 1'b1;
    ticks(LAT);
    chk("coinc_inta2", {7'd0, bus_if.INTA_2});

    // Init_clr in WAIT2 aborts; later pulses are ignored.
    push("abort_inta2_pre", 8'd1);
    push("abort_inta2", 8'd0);
    push("abort_freeze", 8'd0);
    push("abort_int", 8'd0);
    push("abort_data_en", 8'd0);
    push("abort_isr_clear", 8'd0);
    push("abort_inta2_post", 8'd0);
    req_valid = 1'b1;
    req_index = 3'd1;
    tick();
    bus_if.INTA_N = 1'b0;
    ticks(LAT);
    req_valid = 1'b0;
    bus_if.INTA_N = 1'b1;
    ticks(LAT);
    chk("abort_inta2_pre", {7'd0, bus_if.INTA_2});
    init_clr = 1'b1;
    tick();
    init_clr = 1'b0;
    chk("abort_inta2", {7'd0, bus_if.INTA_2});
    chk("abort_freeze", {7'd0, freeze});
    chk("abort_int", {7'd0, bus_if.INT});
    bus_if.INTA_N = 1'b0;
    ticks(LAT);
    chk("abort_data_en", {7'd0, bus_if.Data_en});
    bus_if.INTA_N = 1'b1;
    ticks(LAT);
    chk("abort_isr_clear", {7'd0, isr_clear});
    chk("abort_inta2_post", {7'd0, bus_if.INTA_2});

    // Asynchronous reset while in ACK2.
    push("rst_pre_data_en", 8'd1);
    req_valid = 1'b1;
    req_index = 3'd6;
    tick();
    bus_if.INTA_N = 1'b0;
    ticks(LAT);
    req_valid = 1'b0;
    bus_if.INTA_N = 1'b1;
    ticks(LAT);
    bus_if.INTA_N = 1'b0;
    ticks(LAT);
    chk("rst_pre_data_en", {7'd0, bus_if.Data_en});
    #1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_ack2");
    bus_if.INTA_N = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

    // Normal operation after reset.
    run_ack(3'd4, 1'b0, 1'b1, 1'b1);

    checks++;
    assert (sb_q.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- Clocked interrupt-acknowledge sequencer of the 8259A-compatible PIC control path.
- Sits between the priority resolver / ISR and the cascade buffer.
- Raises INT to the CPU and tracks the two 8086-mode INTA pulses.
- Drives INTA_2, which the cascade buffer uses to gate the CAS bus, and decides whether this device places the vector byte on the data bus.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for the asynchronous INTA_N input (≥2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- INTA_N  input  1  CPU acknowledge strobe, active low, asynchronous.
- Init_clr  input  1  synchronous abort, pulsed on an ICW1 write.
- Req_valid  input  1  priority resolver has an unmasked request above current priority.
- Req_index  input  3  index of that request.
- SNGL  input  1  1 = single PIC, 0 = cascade.
- Master_Slave  input  1  from cascade buffer: 1 master, 0 slave.
- ID  input  3  from cascade buffer: CAS value latched in slave mode.
- Own_ID  input  3  ICW3 slave identity.
- Slave_map  input  8  ICW3 master map: bit n = 1 means a slave is on IRn.
- AEOI  input  1  automatic end-of-interrupt enable.
- Vector_base  input  5  ICW2 T7..T3.
- INT  output  1  interrupt request to the CPU, or to the master IR when this device is a slave.
- INTA_2  output  1  to cascade buffer; high between end of first pulse and end of second pulse.
- ISR_set  output  1  one-cycle pulse setting ISR bit ISR_index.
- ISR_clear  output  1  one-cycle pulse clearing ISR bit ISR_index (AEOI).
- ISR_index  output  3  current acknowledged level.
- Freeze  output  1  holds the IRR/priority resolver stable during the sequence.
- Data_out  output  8  vector byte.
- Data_en  output  1  data-bus drive enable.

Behaviour:
- **Reset.** Asynchronous on reset_n low. All outputs go to 0 and the state to IDLE.
- **Input synchronisation.** INTA_N passes through SYNC_STAGES flops; edges are detected on the synchronised signal.
  - "fall" means a synchronised 1→0 edge; "rise" means a synchronised 0→1 edge.
  - A pin edge is acted on SYNC_STAGES+1 cycles later.
- **States:** IDLE, REQ, ACK1, WAIT2, ACK2.
- **IDLE**
  - Req_valid=1 → REQ; INT=1 from the next cycle.
  - A fall while in IDLE is ignored.
- **REQ**
  - INT=1.
  - On fall → ACK1; INT=0, Freeze=1.
  - Cur_index is latched from Req_index if Req_valid=1. Otherwise the acknowledge is spurious: Cur_index=7 and a spurious flag is set.
  - ISR_set pulses for one cycle on the transition unless spurious.
  - Req_valid dropping while in REQ before a fall: INT stays high (the CPU is already committed).
- **ACK1**
  - On rise → WAIT2; INTA_2=1.
- **WAIT2**
  - On fall → ACK2.
  - Drive decision, fixed on entry to ACK2:
    - SNGL=1 → drive.
    - Master → drive iff Slave_map[Cur_index]=0.
    - Slave → drive iff ID==Own_ID.
- **ACK2**
  - Data_en=drive.
  - Data_out={Vector_base, Cur_index} whenever Data_en=1, else 0.
  - On rise → IDLE. Data_en=0, INTA_2=0, Freeze=0.
  - ISR_clear pulses one cycle with ISR_index=Cur_index if AEOI=1 and not spurious.
- **ISR_index** equals Cur_index from ACK1 entry until the next ACK1.
- **Back-to-back requests.** A new Req_valid in the IDLE cycle after completion re-enters REQ normally; there is no lost cycle beyond the single IDLE cycle.
- **Init_clr.** Highest priority, synchronous. Forces IDLE and clears INT, INTA_2, Freeze and Data_en. ISR pulses are suppressed that cycle.
- **Reset mid-sequence.** reset_n low during any state returns immediately to IDLE with all outputs 0. The synchroniser flops reset to 1 (INTA inactive).
- **Simultaneous events.** A fall and Init_clr in the same cycle → Init_clr wins.

Test Plan:
- **Single mode, AEOI=0.**
  - Stimulus: SNGL=1, Vector_base=5'b01000, Req_valid=1, Req_index=3, two INTA pulses.
  - Required: INT=1 → 0 at first fall; ISR_set pulse with index 3; INTA_2 high between pulses; Data_en=1 with Data_out=8'h43 during second pulse; no ISR_clear.
- **Spurious.**
  - Stimulus: Req_valid drops before first fall.
  - Required: no ISR_set; Data_out=8'h47 in second pulse (base 01000).
- **Cascade master with slave on IR2.**
  - Stimulus: SNGL=0, Master_Slave=1, Slave_map=8'h04, Req_index=2.
  - Required: INTA_2 high between pulses; Data_en stays 0.
- **Repeat with Req_index=5, Slave_map=8'h04.**
  - Required: Data_en=1, Data_out={base,3'd5}.
- **Cascade slave.**
  - Stimulus: Master_Slave=0, Own_ID=2, AEOI=1.
  - Case ID=2: Data_en=1, then ISR_clear pulse on second rise.
  - Case ID=4: Data_en=0.
- **Abort and reset.**
  - Init_clr pulsed in WAIT2: next cycle state IDLE, INTA_2=0, Freeze=0, no ISR_clear.
  - reset_n low in ACK2: all outputs 0 immediately.
